// File: rtl/vga_timing.sv
// VGA raster timing generator: column/row counters with registered, zero-skew
// sync, visible and line/frame start strobes, advancing on pixel_en.
module vga_timing #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          SYNC_ACTIVE = 1'b0,
  localparam int unsigned H_WHOLE     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_WHOLE     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int unsigned COLUMN_BITS = $clog2(H_WHOLE),
  localparam int unsigned ROW_BITS    = $clog2(V_WHOLE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pixel_en,
  output logic [COLUMN_BITS-1:0] column,
  output logic [ROW_BITS-1:0]    row,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   visible,
  output logic                   line_start,
  output logic                   frame_start
);

  localparam logic [COLUMN_BITS-1:0] COL_LAST = COLUMN_BITS'(H_WHOLE - 1);
  localparam logic [COLUMN_BITS-1:0] COL_VIS  = COLUMN_BITS'(H_VISIBLE);
  localparam logic [COLUMN_BITS-1:0] HS_FIRST = COLUMN_BITS'(H_VISIBLE + H_FRONT);
  localparam logic [COLUMN_BITS-1:0] HS_LAST  = COLUMN_BITS'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [ROW_BITS-1:0]    ROW_LAST = ROW_BITS'(V_WHOLE - 1);
  localparam logic [ROW_BITS-1:0]    ROW_VIS  = ROW_BITS'(V_VISIBLE);
  localparam logic [ROW_BITS-1:0]    VS_FIRST = ROW_BITS'(V_VISIBLE + V_FRONT);
  localparam logic [ROW_BITS-1:0]    VS_LAST  = ROW_BITS'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [COLUMN_BITS-1:0] col_nxt;
  logic [ROW_BITS-1:0]    row_nxt;
  logic                   line_nxt;
  logic                   frame_nxt;
  logic                   vis_nxt;
  logic                   hs_act;
  logic                   vs_act;

  // Next position; sync/visible decode the next position so they land with it.
  always_comb begin
    col_nxt   = column;
    row_nxt   = row;
    line_nxt  = 1'b0;
    frame_nxt = 1'b0;
    if (pixel_en) begin
      if (column == COL_LAST) begin
        col_nxt  = '0;
        line_nxt = 1'b1;
        if (row == ROW_LAST) begin
          row_nxt   = '0;
          frame_nxt = 1'b1;
        end else begin
          row_nxt = row + ROW_BITS'(1);
        end
      end else begin
        col_nxt = column + COLUMN_BITS'(1);
      end
    end
    vis_nxt = (col_nxt < COL_VIS) && (row_nxt < ROW_VIS);
    hs_act  = (col_nxt >= HS_FIRST) && (col_nxt <= HS_LAST);
    vs_act  = (row_nxt >= VS_FIRST) && (row_nxt <= VS_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      column      <= '0;
      row         <= '0;
      visible     <= 1'b1;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      column      <= col_nxt;
      row         <= row_nxt;
      visible     <= vis_nxt;
      hsync       <= hs_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync       <= vs_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      line_start  <= line_nxt;
      frame_start <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three parameterisations share one stimulus stream and
// are checked every cycle against a position-from-edge-count model.
module tb_vga_timing;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pixel_en = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  logic [9:0] a_col, a_row;
  logic [3:0] b_col;
  logic [2:0] b_row;
  logic [3:0] c_col;
  logic [9:0] c_row;
  logic a_hs, a_vs, a_vis, a_ls, a_fs;
  logic b_hs, b_vs, b_vis, b_ls, b_fs;
  logic c_hs, c_vs, c_vis, c_ls, c_fs;

  vga_timing u_a (
    .clk(clk), .reset(reset), .pixel_en(pixel_en), .column(a_col), .row(a_row),
    .hsync(a_hs), .vsync(a_vs), .visible(a_vis), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE(1'b1)
  ) u_b (
    .clk(clk), .reset(reset), .pixel_en(pixel_en), .column(b_col), .row(b_row),
    .hsync(b_hs), .vsync(b_vs), .visible(b_vis), .line_start(b_ls), .frame_start(b_fs)
  );

  // Short lines, full-height default vertical timing: a whole frame is 12*525 clks.
  vga_timing #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1)
  ) u_c (
    .clk(clk), .reset(reset), .pixel_en(pixel_en), .column(c_col), .row(c_row),
    .hsync(c_hs), .vsync(c_vs), .visible(c_vis), .line_start(c_ls), .frame_start(c_fs)
  );

  // Model state: enabled edges since reset, and what happened at the last edge.
  int n = 0;
  bit en_last = 1'b0;
  bit rst_last = 1'b1;
  bit started = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      n        = 0;
      rst_last = 1'b1;
      en_last  = 1'b0;
      started  = 1'b1;
    end else begin
      rst_last = 1'b0;
      en_last  = pixel_en;
      if (pixel_en) n = n + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input string tag, input int hv, input int hf, input int hsw,
                          input int hb, input int vv, input int vf, input int vsw,
                          input int vb, input bit sa, input logic [31:0] col,
                          input logic [31:0] row, input logic vis, input logic hs,
                          input logic vs, input logic ls, input logic fs);
    int hw = hv + hf + hsw + hb;
    int vw = vv + vf + vsw + vb;
    int ec = n % hw;
    int er = (n / hw) % vw;
    bit el = !rst_last && en_last && (ec == 0);
    bit ef = el && (er == 0);
    bit ehs = (ec >= hv + hf && ec < hv + hf + hsw) ? sa : !sa;
    bit evs = (er >= vv + vf && er < vv + vf + vsw) ? sa : !sa;
    chk({tag, ".column"}, col, ec);
    chk({tag, ".row"}, row, er);
    chk({tag, ".visible"}, 32'(vis), 32'((ec < hv) && (er < vv)));
    chk({tag, ".hsync"}, 32'(hs), 32'(ehs));
    chk({tag, ".vsync"}, 32'(vs), 32'(evs));
    chk({tag, ".line_start"}, 32'(ls), 32'(el));
    chk({tag, ".frame_start"}, 32'(fs), 32'(ef));
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (started) begin
      chk_inst("a", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 32'(a_col), 32'(a_row),
               a_vis, a_hs, a_vs, a_ls, a_fs);
      chk_inst("b", 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 32'(b_col), 32'(b_row),
               b_vis, b_hs, b_vs, b_ls, b_fs);
      chk_inst("c", 8, 1, 2, 1, 480, 10, 2, 33, 1'b0, 32'(c_col), 32'(c_row),
               c_vis, c_hs, c_vs, c_ls, c_fs);
    end
  end

  task automatic step(input bit r, input bit e);
    reset    = r;
    pixel_en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int cnt);
    for (int i = 0; i < cnt; i++) step(1'b0, 1'b1);
  endtask

  int vs_cnt;
  int fs_cnt;

  initial begin
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("rst.column", 32'(a_col), 0);
    chk("rst.visible", 32'(a_vis), 1);
    chk("rst.hsync", 32'(a_hs), 1);
    chk("rst.vsync", 32'(a_vs), 1);
    chk("rst.line_start", 32'(a_ls), 0);
    chk("rst.b_hsync", 32'(b_hs), 0);

    step(1'b0, 1'b1);
    chk("first.column", 32'(a_col), 1);
    chk("first.line_start", 32'(a_ls), 0);
    run(639);
    chk("h640.column", 32'(a_col), 640);
    chk("h640.visible", 32'(a_vis), 0);
    chk("h640.hsync", 32'(a_hs), 1);
    run(16);
    chk("h656.hsync", 32'(a_hs), 0);
    run(95);
    chk("h751.hsync", 32'(a_hs), 0);
    run(1);
    chk("h752.column", 32'(a_col), 752);
    chk("h752.hsync", 32'(a_hs), 1);
    run(48);
    chk("h800.column", 32'(a_col), 0);
    chk("h800.row", 32'(a_row), 1);
    chk("h800.line_start", 32'(a_ls), 1);
    chk("h800.frame_start", 32'(a_fs), 0);
    run(1);
    chk("h801.line_start", 32'(a_ls), 0);

    for (int i = 0; i < 8; i++) step(1'b0, (i % 2) == 0);
    chk("toggle.column", 32'(a_col), 5);

    step(1'b1, 1'b1);
    vs_cnt = 0;
    fs_cnt = 0;
    for (int i = 1; i <= 6300; i++) begin
      step(1'b0, 1'b1);
      if (c_vs == 1'b0) vs_cnt++;
      if (c_fs == 1'b1) fs_cnt++;
      if (i == 9)  chk("b.col9.hsync", 32'(b_hs), 1);
      if (i == 11) chk("b.col11.hsync", 32'(b_hs), 0);
      if (i == 60) chk("b.row5.vsync", 32'(b_vs), 1);
      if (i == 72) chk("b.row6.vsync", 32'(b_vs), 0);
      if (i == 490 * 12) chk("c.row490.vsync", 32'(c_vs), 0);
    end
    chk("c.frame.column", 32'(c_col), 0);
    chk("c.frame.row", 32'(c_row), 0);
    chk("c.frame.frame_start", 32'(c_fs), 1);
    chk("c.frame.line_start", 32'(c_ls), 1);
    chk("c.frame.vsync_clks", vs_cnt, 24);
    chk("c.frame.fs_pulses", fs_cnt, 1);
    chk("b.frame.frame_start", 32'(b_fs), 1);
    chk("a.6300.column", 32'(a_col), 700);
    chk("a.6300.row", 32'(a_row), 7);

    run(1);
    chk("c.after.frame_start", 32'(c_fs), 0);
    run(3606);
    chk("c.mid.row", 32'(c_row), 300);
    chk("c.mid.column", 32'(c_col), 7);
    step(1'b1, 1'b1);
    chk("c.midrst.column", 32'(c_col), 0);
    chk("c.midrst.row", 32'(c_row), 0);
    chk("c.midrst.visible", 32'(c_vis), 1);
    chk("c.midrst.hsync", 32'(c_hs), 1);
    chk("c.midrst.vsync", 32'(c_vs), 1);
    chk("c.midrst.line_start", 32'(c_ls), 0);
    step(1'b0, 1'b1);
    chk("c.postrst.column", 32'(c_col), 1);
    chk("c.postrst.line_start", 32'(c_ls), 0);
    run(20);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
